serial_transmitter: RTL and testbench

Parallel-in, serial-out transmitter for the 4-bit shift-register receiver path. It accepts a WIDTH-bit word through a load/ready handshake and shifts the word out LSB-first, one bit per clock, on `out`. Drive `out` straight into the receiver's serial input on the same clock. After WIDTH shifts the receiver holds the word with bit 0 in its lowest stage (Q0) and bit WIDTH-1 in its highest stage (Q3 for WIDTH=4).

---
 rtl/serial_transmitter.sv | 89 ++++++++
 tb/tb_serial_transmitter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_transmitter.sv
// Parallel-in, serial-out transmitter: shifts a WIDTH-bit word out LSB-first.
// Optional even-parity trailer bit when SERIAL_TX_PARITY_EN is defined.
module serial_transmitter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic             out,
  output logic             ready,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sh_q, sh_d;
  logic [N-1:0]    frame;

`ifdef SERIAL_TX_PARITY_EN
  assign frame = {^D, D};
`else
  assign frame = D;
`endif

  // Shift register is cleared whenever idle, so its LSB doubles as the output.
  assign out   = sh_q[0];
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == SHIFT) && (cnt_q == LAST);
  assign ready = (state_q == IDLE) || done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = frame;
        end
      end
      SHIFT: begin
        if (done) begin
          cnt_d = '0;
          if (load) begin
            sh_d = frame;
          end else begin
            state_d = IDLE;
            sh_d    = '0;
          end
        end else begin
          sh_d  = {1'b0, sh_q[N-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sh_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench for serial_transmitter: frame-level reference model
// plus a same-clock receiver shift register fed from out.
module tb_serial_transmitter;
  localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         load  = 1'b0;
  logic [W-1:0] D     = '0;
  logic         out, ready, busy, done;
  logic [N-1:0] rx;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] wq[$];

  serial_transmitter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .load(load), .D(D),
    .out(out), .ready(ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Receiver: new bit enters the top stage, so bit 0 ends in rx[0].
  always @(posedge clock) rx <= {out, rx[N-1:1]};

  function automatic logic fbit(input logic [W-1:0] w, input int k);
    if (k < W) return w[k];
    return ^w;
  endfunction

  function automatic logic [N-1:0] fword(input logic [W-1:0] w);
    logic [N-1:0] f;
    for (int k = 0; k < N; k++) f[k] = fbit(w, k);
    return f;
  endfunction

  // Sends every word in wq back-to-back (starting from idle) and checks each cycle.
  // noisy: 0 = load low mid-frame, 1 = load high with D=0, 2 = load high with random D.
  task automatic run_frames(input int noisy, input string name);
    int m;
    int k;
    int idx;
    logic exp_done;
    m = wq.size();
    @(negedge clock);
    load = 1'b1;
    D    = wq[0];
    for (int c = 1; c <= m * N; c++) begin
      @(negedge clock);
      k = (c - 1) % N;
      idx = (c - 1) / N;
      exp_done = (k == N - 1);
      checks++;
      if (out !== fbit(wq[idx], k) || done !== exp_done || busy !== 1'b1 || ready !== exp_done) begin
        errors++;
        $display("FAIL %s cycle %0d: out=%b done=%b busy=%b ready=%b, expected out=%b done=%b busy=1 ready=%b",
                 name, c, out, done, busy, ready, fbit(wq[idx], k), exp_done, exp_done);
      end
      if (k == 0 && idx > 0) begin
        checks++;
        if (rx !== fword(wq[idx-1])) begin
          errors++;
          $display("FAIL %s rx word %0d: got %b expected %b", name, idx - 1, rx, fword(wq[idx-1]));
        end
      end
      if (k == N - 1 && idx + 1 < m) begin
        load = 1'b1;
        D    = wq[idx+1];
      end else if (k == N - 1) begin
        load = 1'b0;
        D    = W'($urandom);
      end else begin
        load = (noisy != 0);
        D    = (noisy == 1) ? '0 : W'($urandom);
      end
    end
    @(negedge clock);
    load = 1'b0;
    checks++;
    if (out !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle after: out=%b done=%b busy=%b ready=%b, expected 0 0 0 1",
               name, out, done, busy, ready);
    end
    checks++;
    if (rx !== fword(wq[m-1])) begin
      errors++;
      $display("FAIL %s rx last word: got %b expected %b", name, rx, fword(wq[m-1]));
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%b ready=%b busy=%b done=%b, expected 0 1 0 0", out, ready, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (out !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle hold %0d: out=%b ready=%b busy=%b done=%b, expected 0 1 0 0",
                 i, out, ready, busy, done);
      end
    end
  endtask

  task automatic test_single();
    wq.delete();
    wq.push_back(4'b1011);
    run_frames(0, "single");
  endtask

  task automatic test_back_to_back();
    wq.delete();
    wq.push_back(4'b0110);
    wq.push_back(4'b1001);
    run_frames(0, "back_to_back");
  endtask

  task automatic test_ignore();
    wq.delete();
    wq.push_back(4'b1111);
    run_frames(1, "ignore_load");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    load = 1'b1;
    D    = 4'b1010;
    @(negedge clock);
    load = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%b busy=%b ready=%b done=%b, expected 0 0 1 0", out, busy, ready, done);
    end
    @(negedge clock);
    reset = 1'b0;
    wq.delete();
    wq.push_back(4'b0011);
    run_frames(0, "after_reset");
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 20; t++) begin
      wq.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wq.push_back(W'($urandom));
      run_frames($urandom_range(0, 2), "random");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  task automatic test_parity_zero();
    wq.delete();
    wq.push_back(4'b0000);
    run_frames(0, "zero_word");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_parity_zero();
    wq.delete();
    wq.push_back(4'b0111);
    run_frames(0, "word_0111");
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
